imm_decode_stage: RTL and testbench
===================================

// Module: imm_decode_stage
// PURPOSE
//   Registered, flow-controlled immediate decoder between fetch and execute.
//   Takes a full 32-bit RV instruction and a tag, and decodes the immediate sign-extended to XLEN.
//   It also produces an immediate format code, a CSR zimm and an illegal-encoding flag.
//   A 2-entry elastic buffer decouples the valid/ready handshakes on each side.
// PARAMETERS
//   XLEN   32  datapath width of imm_o; legal values are 32 and 64 only
//   TAG_W  32  width of the sideband tag (normally the PC), passed through unchanged
// PORTS
//   clk_i        in   1      clock; all state changes on the rising edge
//   rst_ni       in   1      asynchronous active-low reset
//   flush_i      in   1      synchronous flush; discards all buffered entries
//   in_valid_i   in   1      upstream instruction valid
//   in_ready_o   out  1      stage can accept an instruction this cycle
//   instr_i      in   32     instruction word
//   tag_i        in   TAG_W  sideband tag
//   out_valid_o  out  1      head entry valid
//   out_ready_i  in   1      downstream accepts the head entry
//   imm_o        out  XLEN   decoded immediate, sign-extended to XLEN
//   imm_type_o   out  3      format: 0=none(R) 1=I 2=S 3=B 4=U 5=J 6=CSR 7=illegal
//   zimm_o       out  5      instr[19:15] for SYSTEM; 0 otherwise
//   illegal_o    out  1      unsupported opcode, or instr[1:0]!=2'b11
//   tag_o        out  TAG_W  tag of the head entry
// BEHAVIOUR
// - Decode (combinational on instr_i, captured into the buffer on push):
//   - I: opcodes 0010011, 0000011, 1100111.
//     imm = sext(instr[31:20]).
//   - S: opcode 0100011.
//     imm = sext({instr[31:25], instr[11:7]}).
//   - B: opcode 1100011.
//     imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
//   - U: opcodes 0110111, 0010111.
//     imm = sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 copy instr[31].
//   - J: opcode 1101111.
//     imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
//   - CSR: opcode 1110011.
//     imm = sext(instr[31:20]) (CSR address); zimm_o = instr[19:15].
//   - none (R): opcodes 0110011, 0001111.
//     imm = 0, type 0, legal.
//   - illegal: any other opcode, or instr[1:0]!=2'b11.
//     imm = 0, type 7, illegal_o = 1.
//   - zimm_o = 0 for every non-SYSTEM opcode.
// - Buffer state machine (count in {0,1,2}):
//   - in_ready_o = (count!=2); driven only by registered state, so there is no combinational path from out_ready_i.
//   - out_valid_o = (count!=0).
//   - Head outputs are driven from registers.
//   - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//   - count=0: push -> count 1.
//   - count=1:
//     - push only -> count 2.
//     - pop only -> count 0.
//     - push & pop -> count 1, and the new entry becomes the head.
//   - count=2:
//     - pop -> count 1, and the second entry becomes the head.
//     - No push is possible in this state.
// - Latency: an instruction pushed at edge N is visible on out_valid_o/imm_o after edge N (1 cycle).
// - Order is strictly FIFO. The head entry and its outputs are held stable while out_valid_o=1 and out_ready_i=0.
// - flush_i:
//   - next count = 0.
//   - A push in the same cycle is dropped.
//   - Flush takes priority over push and pop.
//   - in_ready_o is not gated by flush_i.
// - Reset (rst_ni=0, asynchronous):
//   - count = 0.
//   - out_valid_o = 0 and in_ready_o = 1.
//   - imm_o, imm_type_o, zimm_o, illegal_o and tag_o = 0.
//   - Reset mid-transfer discards all entries.
// TESTING
// - addi x1,x0,-1 (0xFFF00093), XLEN=64, out_ready=1 -> one cycle later imm_o=64'hFFFF_FFFF_FFFF_FFFF, type 1.
// - Coverage sweep: sw (0xFE112E23) -> imm=-4, type 2; beq (0xFE000EE3) -> imm=-4, type 3;
//   lui (0x800000B7), XLEN=64 -> imm=64'hFFFF_FFFF_8000_0000, type 4; jal (0x0080006F) -> imm=8, type 5.
// - csrrwi (0x3405D073) -> imm=0x340, zimm=11, type 6.
//   Opcode 0x7F -> illegal_o=1, type 7, imm=0.
//   instr=0x00000001 -> illegal_o=1.
// - Backpressure: out_ready=0, push A,B -> in_ready falls to 0 after 2 pushes.
//   Raise out_ready -> A then B emitted in order, with A held stable while stalled.
// - Full-rate stream: in_valid=1 and out_ready=1 for 8 cycles -> count stays 1, and 8 entries are emitted in order.
// - Flush with count=2 plus a simultaneous push -> next cycle out_valid=0 and nothing appears from the dropped push.
//   Separately, assert rst_ni low asynchronously mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decoder between fetch and execute.
// Decodes the immediate, its format, the CSR zimm and an illegal flag from a
// 32-bit RV instruction, and holds results in a 2-entry elastic buffer so the
// upstream ready never depends combinationally on the downstream ready.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       imm_type_o,
  output logic [4:0]       zimm_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [2:0] TYPE_NONE    = 3'd0;
  localparam logic [2:0] TYPE_I       = 3'd1;
  localparam logic [2:0] TYPE_S       = 3'd2;
  localparam logic [2:0] TYPE_B       = 3'd3;
  localparam logic [2:0] TYPE_U       = 3'd4;
  localparam logic [2:0] TYPE_J       = 3'd5;
  localparam logic [2:0] TYPE_CSR     = 3'd6;
  localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // One buffer entry: {imm, type, zimm, illegal, tag}
  localparam int ENTRY_W = XLEN + 3 + 5 + 1 + TAG_W;

  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]    dec_imm;
  logic [2:0]         dec_type;
  logic [4:0]         dec_zimm;
  logic               dec_illegal;

  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] second_q;

  state_t state_q;
  state_t state_d;

  logic push;
  logic pop;
  logic load_head_new;
  logic load_second_new;
  logic shift_second;

  // Decode the incoming word; every immediate is first built as a signed 32-bit value
  always_comb begin
    dec_imm32   = '0;
    dec_type    = TYPE_ILLEGAL;
    dec_zimm    = '0;
    dec_illegal = 1'b1;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:0])
        OP_IMM, OP_LOAD, OP_JALR: begin
          dec_imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
          dec_type    = TYPE_I;
          dec_illegal = 1'b0;
        end
        OP_STORE: begin
          dec_imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
          dec_type    = TYPE_S;
          dec_illegal = 1'b0;
        end
        OP_BRANCH: begin
          dec_imm32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
          dec_type    = TYPE_B;
          dec_illegal = 1'b0;
        end
        OP_LUI, OP_AUIPC: begin
          dec_imm32   = {instr_i[31:12], 12'b0};
          dec_type    = TYPE_U;
          dec_illegal = 1'b0;
        end
        OP_JAL: begin
          dec_imm32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
          dec_type    = TYPE_J;
          dec_illegal = 1'b0;
        end
        OP_SYSTEM: begin
          dec_imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
          dec_type    = TYPE_CSR;
          dec_zimm    = instr_i[19:15];
          dec_illegal = 1'b0;
        end
        OP_REG, OP_FENCE: begin
          dec_type    = TYPE_NONE;
          dec_illegal = 1'b0;
        end
        default: begin
          dec_type    = TYPE_ILLEGAL;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // Casting the signed 32-bit value up to XLEN sign-extends it (no-op when XLEN is 32)
  assign dec_imm   = XLEN'(dec_imm32);
  assign new_entry = {dec_imm, dec_type, dec_zimm, dec_illegal, tag_i};

  // Handshake flags come from the registered state only
  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Occupancy state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and which buffer slots load this cycle; flush wins over push and pop
  always_comb begin
    state_d         = state_q;
    load_head_new   = 1'b0;
    load_second_new = 1'b0;
    shift_second    = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d       = ONE;
            load_head_new = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head_new = 1'b1;
          end else if (push) begin
            state_d         = TWO;
            load_second_new = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d      = ONE;
            shift_second = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Buffer slots; the head only changes on a load or a shift, so it holds while stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      second_q <= '0;
    end else begin
      if (load_head_new) begin
        head_q <= new_entry;
      end else if (shift_second) begin
        head_q <= second_q;
      end
      if (load_second_new) begin
        second_q <= new_entry;
      end
    end
  end

  assign {imm_o, imm_type_o, zimm_o, illegal_o, tag_o} = head_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed table, hand-written flow-control sequences and
// randomized traffic checked against a queue-based reference model.
module tb_imm_decode_stage;

  localparam int XLEN  = 64;
  localparam int TAG_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [31:0]      instr_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       imm_type_o;
  logic [4:0]       zimm_o;
  logic             illegal_o;
  logic [TAG_W-1:0] tag_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic [4:0]  zimm;
    logic        ill;
    logic [31:0] tag;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic [4:0]  zimm;
    logic        ill;
  } vec_t;

  ent_t model[$];
  vec_t vecs[13];

  imm_decode_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .imm_o       (imm_o),
    .imm_type_o  (imm_type_o),
    .zimm_o      (zimm_o),
    .illegal_o   (illegal_o),
    .tag_o       (tag_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference decode: immediate values computed as plain integers from the field values
  function automatic ent_t refEntry(input logic [31:0] ins, input logic [31:0] tg);
    ent_t e;
    longint v;
    v = 0;
    e.tag  = tg;
    e.zimm = '0;
    e.ill  = 1'b0;
    e.ty   = 3'd0;
    if (ins[1:0] != 2'b11) begin
      e.ty  = 3'd7;
      e.ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67: begin
          e.ty = 3'd1;
          v = longint'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
        end
        7'h23: begin
          e.ty = 3'd2;
          v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
          if (v >= 2048) v = v - 4096;
        end
        7'h63: begin
          e.ty = 3'd3;
          v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
          if (v >= 4096) v = v - 8192;
        end
        7'h37, 7'h17: begin
          e.ty = 3'd4;
          v = longint'(ins[31:12]) * 4096;
          if (ins[31]) v = v - (longint'(1) << 32);
        end
        7'h6F: begin
          e.ty = 3'd5;
          v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
          if (v >= 1048576) v = v - 2097152;
        end
        7'h73: begin
          e.ty = 3'd6;
          e.zimm = ins[19:15];
          v = longint'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
        end
        7'h33, 7'h0F: begin
          e.ty = 3'd0;
        end
        default: begin
          e.ty  = 3'd7;
          e.ill = 1'b1;
        end
      endcase
    end
    e.imm = 64'(v);
    return e;
  endfunction

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model queue head
  task automatic checkOutput();
    checkField("out_valid", 64'(out_valid_o), 64'(model.size() != 0));
    checkField("in_ready", 64'(in_ready_o), 64'(model.size() < 2));
    if (model.size() != 0) begin
      checkField("head_imm", imm_o, model[0].imm);
      checkField("head_type", 64'(imm_type_o), 64'(model[0].ty));
      checkField("head_zimm", 64'(zimm_o), 64'(model[0].zimm));
      checkField("head_illegal", 64'(illegal_o), 64'(model[0].ill));
      checkField("head_tag", 64'(tag_o), 64'(model[0].tag));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rdy, input logic [31:0] ins,
                               input logic [31:0] tg, input logic fl);
    in_valid_i  = v;
    out_ready_i = rdy;
    instr_i     = ins;
    tag_i       = tg;
    flush_i     = fl;
  endtask

  // Check at the negedge, clock once, then advance the model exactly as the handshake rules say
  task automatic runCycle();
    bit push;
    bit pop;
    checkOutput();
    push = in_valid_i && (model.size() < 2);
    pop  = (model.size() != 0) && out_ready_i;
    @(posedge clk_i);
    if (flush_i) begin
      model.delete();
    end else begin
      if (pop) void'(model.pop_front());
      if (push) model.push_back(refEntry(instr_i, tag_i));
    end
    @(negedge clk_i);
  endtask

  logic [6:0] opcodes[12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                              7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 5'd0,  1'b0};
    vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 5'd0,  1'b0};
    vecs[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 5'd0,  1'b0};
    vecs[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 5'd0,  1'b0};
    vecs[4]  = '{32'h0080006F, 64'd8,                   3'd5, 5'd0,  1'b0};
    vecs[5]  = '{32'h3405D073, 64'h340,                 3'd6, 5'd11, 1'b0};
    vecs[6]  = '{32'h0000007F, 64'd0,                   3'd7, 5'd0,  1'b1};
    vecs[7]  = '{32'h00000001, 64'd0,                   3'd7, 5'd0,  1'b1};
    vecs[8]  = '{32'h00B50533, 64'd0,                   3'd0, 5'd0,  1'b0};
    vecs[9]  = '{32'h0000000F, 64'd0,                   3'd0, 5'd0,  1'b0};
    vecs[10] = '{32'h00812083, 64'd8,                   3'd1, 5'd0,  1'b0};
    vecs[11] = '{32'h000080E7, 64'd0,                   3'd1, 5'd0,  1'b0};
    vecs[12] = '{32'h00001097, 64'h1000,                3'd4, 5'd0,  1'b0};

    // Asynchronous reset before any clock edge
    #1 rst_ni = 1'b0;
    #1;
    checkField("rst_valid", 64'(out_valid_o), 64'd0);
    checkField("rst_ready", 64'(in_ready_o), 64'd1);
    checkField("rst_imm", imm_o, 64'd0);
    checkField("rst_tag", 64'(tag_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed decode table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b0);
      runCycle();
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      checkField("tbl_valid", 64'(out_valid_o), 64'd1);
      checkField("tbl_imm", imm_o, vecs[i].imm);
      checkField("tbl_type", 64'(imm_type_o), 64'(vecs[i].ty));
      checkField("tbl_zimm", 64'(zimm_o), 64'(vecs[i].zimm));
      checkField("tbl_illegal", 64'(illegal_o), 64'(vecs[i].ill));
      checkField("tbl_tag", 64'(tag_o), 64'(32'h1000 + 32'(i * 4)));
      runCycle();
    end

    // Backpressure: two pushes fill the buffer, head held while stalled, then FIFO drain
    $display("[TB] backpressure sequence");
    applyStimulus(1'b1, 1'b0, 32'hFFF00093, 32'hA, 1'b0);
    runCycle();
    checkField("bp_ready_one", 64'(in_ready_o), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h00812083, 32'hB, 1'b0);
    runCycle();
    checkField("bp_ready_full", 64'(in_ready_o), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h00B50533, 32'hC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      runCycle();
      checkField("bp_hold_tag", 64'(tag_o), 64'hA);
      checkField("bp_hold_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    runCycle();
    checkField("bp_second_tag", 64'(tag_o), 64'hB);
    checkField("bp_second_imm", imm_o, 64'd8);
    runCycle();
    checkField("bp_drained", 64'(out_valid_o), 64'd0);

    // Full-rate stream: push and pop every cycle, head is always the newest entry
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, (32'(i) << 20) | 32'h93, 32'h2000 + 32'(i), 1'b0);
      runCycle();
      checkField("stream_ready", 64'(in_ready_o), 64'd1);
      checkField("stream_tag", 64'(tag_o), 64'(32'h2000 + 32'(i)));
      checkField("stream_imm", imm_o, 64'(i));
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    runCycle();

    // Flush with a full buffer and in_valid held high
    applyStimulus(1'b1, 1'b0, 32'h0080006F, 32'h31, 1'b0);
    runCycle();
    applyStimulus(1'b1, 1'b0, 32'h0080006F, 32'h32, 1'b0);
    runCycle();
    applyStimulus(1'b1, 1'b0, 32'h3405D073, 32'h33, 1'b1);
    runCycle();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    checkField("flush2_valid", 64'(out_valid_o), 64'd0);
    checkField("flush2_ready", 64'(in_ready_o), 64'd1);
    runCycle();
    checkField("flush2_quiet", 64'(out_valid_o), 64'd0);

    // Flush with one entry while a push is actually accepted by the handshake
    applyStimulus(1'b1, 1'b0, 32'h0080006F, 32'h41, 1'b0);
    runCycle();
    applyStimulus(1'b1, 1'b1, 32'hFE112E23, 32'h42, 1'b1);
    runCycle();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    checkField("flush1_valid", 64'(out_valid_o), 64'd0);
    runCycle();
    checkField("flush1_quiet", 64'(out_valid_o), 64'd0);

    // Asynchronous reset mid-stream clears everything without waiting for a clock
    applyStimulus(1'b1, 1'b0, 32'h3405D073, 32'h51, 1'b0);
    runCycle();
    runCycle();
    #2 rst_ni = 1'b0;
    #1;
    checkField("arst_valid", 64'(out_valid_o), 64'd0);
    checkField("arst_ready", 64'(in_ready_o), 64'd1);
    checkField("arst_imm", imm_o, 64'd0);
    checkField("arst_type", 64'(imm_type_o), 64'd0);
    checkField("arst_zimm", 64'(zimm_o), 64'd0);
    checkField("arst_illegal", 64'(illegal_o), 64'd0);
    checkField("arst_tag", 64'(tag_o), 64'd0);
    model.delete();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Randomized traffic against the model
    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = opcodes[$urandom_range(0, 11)];
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, ins,
                    $urandom, $urandom_range(0, 31) == 0);
      runCycle();
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    repeat (3) runCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
